ops_sched: RTL

Round-robin scheduler that shares one 8-bit ALU (add, sub, and, or, with signed-overflow flag) between NREQ independent requesters. Each requester hands over an operand pair and an opcode through a valid/ready handshake. The block sequences one operation at a time through a registered ALU stage and returns the result with its overflow flag and source index on a single response channel. It sits between the lab's client units and the shared arithmetic datapath.

---
 rtl/ops_pkg.sv | 19 +
 rtl/ops_rr_pick.sv | 35 +++
 rtl/ops_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ops_pkg.sv
// Shared types and constants for the ops_sched round-robin ALU scheduler.
package ops_pkg;

   localparam int DW = 8;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_AND = 2'b10,
      OP_OR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

endpackage

// File: rtl/ops_rr_pick.sv
// Combinational round-robin picker: first valid index searching from i_ptr upward, wrapping at NREQ.
module ops_rr_pick
   import ops_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int SRC_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  i_valid,
   input  logic [SRC_W-1:0] i_ptr,
   output logic [NREQ-1:0]  o_grant,
   output logic [SRC_W-1:0] o_idx,
   output logic             o_any
);

   always_comb begin
      logic [SRC_W:0] j;
      // NOTE: every output gets a default before the search so no latch is inferred.
      o_grant = '0;
      o_idx   = '0;
      o_any   = 1'b0;
      j       = '0;
      // Walk from the farthest candidate back to ptr so the nearest valid one wins.
      for (int k = NREQ - 1; k >= 0; k--) begin
         j = {1'b0, i_ptr} + (SRC_W+1)'(k);
         if (j >= (SRC_W+1)'(NREQ)) j = j - (SRC_W+1)'(NREQ);
         if (i_valid[j[SRC_W-1:0]]) begin
            o_grant                 = '0;
            o_grant[j[SRC_W-1:0]]   = 1'b1;
            o_idx                   = j[SRC_W-1:0];
            o_any                   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ops_sched.sv
// Round-robin scheduler sharing one registered 8-bit ALU among NREQ requesters.
// Optional overflow statistics counter enabled by defining OPS_SCHED_STATS_EN.
module ops_sched
   import ops_pkg::*;
#(
   parameter int NREQ = 4,
   localparam int SRC_W = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*8-1:0] req_a,
   input  logic [NREQ*8-1:0] req_b,
   input  logic [NREQ*2-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DW-1:0]     rsp_o,
   output logic              rsp_ovf,
   output logic [SRC_W-1:0]  rsp_src,
   output logic              busy
`ifdef OPS_SCHED_STATS_EN
   ,
   input  logic              stat_clr,
   output logic [15:0]       stat_ovf_cnt
`endif
);

   state_e            r_state, w_next;
   logic [SRC_W-1:0]  r_ptr, r_src, r_rsp_src, w_idx;
   logic [NREQ-1:0]   w_grant;
   logic              w_any, w_accept, w_rsp_hs;
   logic [DW-1:0]     r_a, r_b, r_rsp_o, w_alu_o;
   op_e               r_op;
   logic              r_rsp_ovf, w_alu_ovf;

   ops_rr_pick #(.NREQ(NREQ)) u_pick (
      .i_valid (req_valid),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   assign w_accept = (r_state == ST_IDLE) && w_any;
   assign w_rsp_hs = (r_state == ST_RESP) && rsp_ready;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_any) w_next = ST_EXEC;
         ST_EXEC: w_next = ST_RESP;
         ST_RESP: if (rsp_ready) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      rsp_valid = 1'b0;
      busy      = 1'b1;
      case (r_state)
         ST_IDLE: begin
            req_ready = w_grant;
            busy      = 1'b0;
         end
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // NOTE: operand capture registers carry no reset; they are always loaded on accept before EXEC reads them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_a   <= req_a[w_idx*DW +: DW];
         r_b   <= req_b[w_idx*DW +: DW];
         r_op  <= op_e'(req_op[w_idx*2 +: 2]);
         r_src <= w_idx;
      end
   end

   always_comb begin
      w_alu_o   = '0;
      w_alu_ovf = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_alu_o   = r_a + r_b;
            w_alu_ovf = (r_a[DW-1] == r_b[DW-1]) && (w_alu_o[DW-1] != r_a[DW-1]);
         end
         OP_SUB: begin
            w_alu_o   = r_a - r_b;
            w_alu_ovf = (r_a[DW-1] != r_b[DW-1]) && (w_alu_o[DW-1] != r_a[DW-1]);
         end
         OP_AND:  w_alu_o = r_a & r_b;
         OP_OR:   w_alu_o = r_a | r_b;
         default: ;
      endcase
   end

   // Response is registered in EXEC; the pointer moves past the served requester on handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr     <= '0;
         r_rsp_o   <= '0;
         r_rsp_ovf <= 1'b0;
         r_rsp_src <= '0;
      end else begin
         if (r_state == ST_EXEC) begin
            r_rsp_o   <= w_alu_o;
            r_rsp_ovf <= w_alu_ovf;
            r_rsp_src <= r_src;
         end
         if (w_rsp_hs) r_ptr <= (r_rsp_src == SRC_W'(NREQ - 1)) ? '0 : r_rsp_src + 1'b1;
      end
   end

   assign rsp_o   = r_rsp_o;
   assign rsp_ovf = r_rsp_ovf;
   assign rsp_src = r_rsp_src;

`ifdef OPS_SCHED_STATS_EN
   logic [15:0] r_stat_cnt;

   always_ff @(posedge clk) begin
      if (rst || stat_clr)
         r_stat_cnt <= '0;
      else if (w_rsp_hs && r_rsp_ovf && (r_stat_cnt != 16'hFFFF))
         r_stat_cnt <= r_stat_cnt + 16'd1;
   end

   assign stat_ovf_cnt = r_stat_cnt;
`endif

endmodule
